// File: rtl/sudoku_validator_if.sv
// sudoku_validator_if
//   Bundles the request/result signals of sudoku_validator.
//   master : requester side (drives start/grid_in, observes results)
//   slave  : validator side (observes start/grid_in, drives results)
//   Signals:
//     start          one-cycle validation request
//     grid_in        81 cells, row-major, CELL_W bits each
//     busy           scan in progress
//     done           one-cycle pulse when results update
//     conflict_mask  bit r*9+c set when cell (r,c) conflicts
//     conflict_count number of set bits in conflict_mask
//     complete       every cell nonzero
//     solved         complete and no conflicts
interface sudoku_validator_if #(
  parameter int CELL_W = 4
);
  logic                  start;
  logic [81*CELL_W-1:0]  grid_in;
  logic                  busy;
  logic                  done;
  logic [80:0]           conflict_mask;
  logic [6:0]            conflict_count;
  logic                  complete;
  logic                  solved;

  modport master (
    output start, grid_in,
    input  busy, done, conflict_mask, conflict_count, complete, solved
  );

  modport slave (
    input  start, grid_in,
    output busy, done, conflict_mask, conflict_count, complete, solved
  );
endinterface

// File: rtl/sudoku_validator.sv
// sudoku_validator
//   Sequential Sudoku rule checker. A start pulse snapshots the grid, then
//   every unit (rows, columns and, optionally, 3x3 boxes) is walked one cell
//   per clock: a COUNT pass records which digits repeat, a MARK pass flags
//   the cells holding those digits. Illegal values (10-15) always conflict.
//   Results are published in a single FINISH cycle together with a done
//   pulse; they hold until the next completed scan.
//
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high; aborts a scan and clears results
//     bus    sudoku_validator_if.slave (start, grid_in, busy, done,
//            conflict_mask, conflict_count, complete, solved)
//
//   Build option:
//     SUDOKU_VALIDATOR_BOX_EN  defined -> box units scanned (27 units);
//                              undefined -> rows and columns only (18 units).
//
//   CELL_W must be at least 4.
module sudoku_validator #(
  parameter int CELL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  sudoku_validator_if.slave  bus
);

`ifdef SUDOKU_VALIDATOR_BOX_EN
  localparam logic [4:0] LAST_U = 5'd26;
`else
  localparam logic [4:0] LAST_U = 5'd17;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, COUNT, MARK, FINISH} state_t;

  state_t                state;
  logic [4:0]            u;
  logic [3:0]            k;

  logic                  busy_r;
  logic                  done_r;
  logic [80:0]           mask_r;
  logic [6:0]            count_r;
  logic                  complete_r;
  logic                  solved_r;

  logic [81*CELL_W-1:0]  snap;
  logic [15:0]           seen;
  logic [15:0]           dup;
  logic [80:0]           wmask;
  logic [6:0]            wcount;
  logic                  wcomplete;

  logic [6:0]            idx;
  logic [CELL_W-1:0]     v;
  logic [3:0]            vi;
  logic                  legal;
  logic                  illegal;

  // Map (unit, position-in-unit) to the flat cell index r*9+c.
  function automatic logic [6:0] cell_idx(input logic [4:0] uu, input logic [3:0] kk);
    int r;
    int c;
    int b;
    r = 0;
    c = 0;
    b = 0;
    if (uu < 5'd9) begin
      r = int'(uu);
      c = int'(kk);
    end else if (uu < 5'd18) begin
      r = int'(kk);
      c = int'(uu) - 9;
    end else begin
      b = int'(uu) - 18;
      r = 3 * (b / 3) + int'(kk) / 3;
      c = 3 * (b % 3) + int'(kk) % 3;
    end
    return 7'(r * 9 + c);
  endfunction

  always_comb begin
    idx     = cell_idx(u, k);
    v       = snap[int'(idx)*CELL_W +: CELL_W];
    vi      = v[3:0];
    legal   = (v != '0) && (v <= CELL_W'(9));
    illegal = (v > CELL_W'(9));
  end

  // Control: state, unit/cell walk and the published results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      u          <= 5'd0;
      k          <= 4'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mask_r     <= '0;
      count_r    <= 7'd0;
      complete_r <= 1'b0;
      solved_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) state <= LOAD;
        end
        LOAD: begin
          u      <= 5'd0;
          k      <= 4'd0;
          busy_r <= 1'b1;
          state  <= COUNT;
        end
        COUNT: begin
          if (k == 4'd8) begin
            k     <= 4'd0;
            state <= MARK;
          end else begin
            k <= k + 4'd1;
          end
        end
        MARK: begin
          if (k == 4'd8) begin
            k <= 4'd0;
            if (u == LAST_U) begin
              // busy drops as FINISH is entered
              busy_r <= 1'b0;
              state  <= FINISH;
            end else begin
              u     <= u + 5'd1;
              state <= COUNT;
            end
          end else begin
            k <= k + 4'd1;
          end
        end
        FINISH: begin
          mask_r     <= wmask;
          count_r    <= wcount;
          complete_r <= wcomplete;
          solved_r   <= wcomplete && (wcount == 7'd0);
          done_r     <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: snapshot and working accumulators, re-initialised in LOAD.
  always_ff @(posedge clk) begin
    case (state)
      LOAD: begin
        snap      <= bus.grid_in;
        seen      <= '0;
        dup       <= '0;
        wmask     <= '0;
        wcount    <= 7'd0;
        wcomplete <= 1'b1;
      end
      COUNT: begin
        if (legal) begin
          if (seen[vi]) dup[vi]  <= 1'b1;
          else          seen[vi] <= 1'b1;
        end
        // Every cell is visited once by the row units alone.
        if ((u < 5'd9) && (v == '0)) wcomplete <= 1'b0;
      end
      MARK: begin
        if ((legal && dup[vi]) || illegal) begin
          wmask[idx] <= 1'b1;
          // Count only first-time flags so cells hit by several units
          // are not double-counted.
          if (!wmask[idx]) wcount <= wcount + 7'd1;
        end
        if (k == 4'd8) begin
          seen <= '0;
          dup  <= '0;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.conflict_mask  = mask_r;
  assign bus.conflict_count = count_r;
  assign bus.complete       = complete_r;
  assign bus.solved         = solved_r;

endmodule

// File: tb/tb_sudoku_validator.sv
// tb_sudoku_validator
//   Directed bench for sudoku_validator: idle after reset, solved grid,
//   swapped cells, box-only duplicate, illegal value, start during a scan,
//   reset during a scan and back-to-back scans with start held high.
//   Honours SUDOKU_VALIDATOR_BOX_EN for latency and box-only expectations.
module tb_sudoku_validator;

`ifdef SUDOKU_VALIDATOR_BOX_EN
  localparam int LAT    = 488;
  localparam bit BOX_ON = 1'b1;
`else
  localparam int LAT    = 326;
  localparam bit BOX_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  sudoku_validator_if #(.CELL_W(4)) bus ();

  sudoku_validator #(.CELL_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [323:0] solved_grid();
    logic [323:0] g;
    g = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        g[(r*9+c)*4 +: 4] = 4'(((r*3 + r/3 + c) % 9) + 1);
    return g;
  endfunction

  function automatic logic [323:0] put(input logic [323:0] g, input int r, input int c, input logic [3:0] val);
    logic [323:0] t;
    t = g;
    t[(r*9+c)*4 +: 4] = val;
    return t;
  endfunction

  task automatic check_results(input string tag, input logic [80:0] m, input int cnt,
                               input bit cpl, input bit slv);
    check_val({tag, "_mask"},     128'(bus.conflict_mask),  128'(m));
    check_val({tag, "_count"},    128'(bus.conflict_count), 128'(cnt));
    check_val({tag, "_complete"}, 128'(bus.complete),       128'(cpl));
    check_val({tag, "_solved"},   128'(bus.solved),         128'(slv));
  endtask

  // Pulses start so that the next rising edge is edge 0, then walks edges
  // 1..LAT+200. start_at / reset_at (0 = unused) raise start / reset for
  // the given edge only; scramble overwrites grid_in after the snapshot.
  task automatic run_scan(input string tag, input int start_at, input int reset_at,
                          input bit scramble, output int first_done, output int n_done);
    first_done = -1;
    n_done     = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int n = 1; n <= LAT + 200; n++) begin
      if (n == start_at) bus.start = 1'b1;
      if (n == reset_at) reset = 1'b1;
      if (scramble && n == 5) bus.grid_in = '1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (n == reset_at) begin
        reset = 1'b0;
        check_val({tag, "_reset_zero"},
                  128'({bus.busy, bus.done, bus.conflict_mask, bus.conflict_count,
                        bus.complete, bus.solved}), 128'(0));
      end
      if (bus.done) begin
        n_done++;
        if (first_done < 0) first_done = n;
      end
      if (reset_at == 0) begin
        if (n == 1)       check_val({tag, "_busy_load"},   128'(bus.busy), 128'(1));
        if (n == LAT - 2) check_val({tag, "_busy_scan"},   128'(bus.busy), 128'(1));
        if (n == LAT - 1) check_val({tag, "_busy_finish"}, 128'(bus.busy), 128'(0));
      end
    end
  endtask

  initial begin
    logic [323:0] g;
    logic [80:0]  m;
    int           fd;
    int           nd;
    int           d1;
    int           d2;

    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.grid_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      check_val("idle",
                128'({bus.busy, bus.done, bus.conflict_mask, bus.conflict_count,
                      bus.complete, bus.solved}), 128'(0));
    end

    // Solved grid; grid_in trashed mid-scan must not matter
    bus.grid_in = solved_grid();
    run_scan("solved", 0, 0, 1'b1, fd, nd);
    check_val("solved_latency", 128'(fd), 128'(LAT));
    check_val("solved_ndone",   128'(nd), 128'(1));
    check_results("solved", '0, 0, 1'b1, 1'b1);

    // Cells (0,0) and (0,1) swapped -> column dups with (3,0) and (8,1)
    g = solved_grid();
    g = put(g, 0, 0, 4'd2);
    g = put(g, 0, 1, 4'd1);
    bus.grid_in = g;
    run_scan("swap", 0, 0, 1'b0, fd, nd);
    check_val("swap_latency", 128'(fd), 128'(LAT));
    m = '0;
    m[0]  = 1'b1;
    m[1]  = 1'b1;
    m[27] = 1'b1;
    m[73] = 1'b1;
    check_results("swap", m, 4, 1'b1, 1'b0);

    // Box-only duplicate
    g = '0;
    g = put(g, 0, 0, 4'd5);
    g = put(g, 1, 1, 4'd5);
    bus.grid_in = g;
    run_scan("box", 0, 0, 1'b0, fd, nd);
    check_val("box_latency", 128'(fd), 128'(LAT));
    m = '0;
    if (BOX_ON) begin
      m[0]  = 1'b1;
      m[10] = 1'b1;
      check_results("box", m, 2, 1'b0, 1'b0);
    end else begin
      check_results("box", m, 0, 1'b0, 1'b0);
    end

    // Illegal value, plus a start at edge 100 that must be ignored
    g = '0;
    g = put(g, 4, 4, 4'd12);
    bus.grid_in = g;
    run_scan("illegal", 100, 0, 1'b0, fd, nd);
    check_val("illegal_latency", 128'(fd), 128'(LAT));
    check_val("illegal_ndone",   128'(nd), 128'(1));
    m = '0;
    m[40] = 1'b1;
    check_results("illegal", m, 1, 1'b0, 1'b0);

    // Reset at edge 200 of a scan: immediate zeros and no done
    bus.grid_in = solved_grid();
    run_scan("rst", 0, 200, 1'b0, fd, nd);
    check_val("rst_ndone", 128'(nd), 128'(0));
    check_results("rst", '0, 0, 1'b0, 1'b0);

    // start held high: second scan starts on the IDLE cycle after FINISH
    d1 = -1;
    d2 = -1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 1; n <= 2*LAT + 10; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (d1 < 0)      d1 = n;
        else if (d2 < 0) d2 = n;
      end
    end
    bus.start = 1'b0;
    check_val("held_done1", 128'(d1), 128'(LAT));
    check_val("held_done2", 128'(d2), 128'(2*LAT + 1));
    check_results("held", '0, 0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sudoku_validator.md
# sudoku_validator

Sequential rule checker between `sudoku_engine` and `sudoku_draw`. On a start pulse it snapshots the 81-cell grid and walks every row, column and 3x3 box one cell per clock. It flags each cell whose value repeats within any of its units. It produces a per-cell conflict mask for on-screen highlighting, plus solved/complete status for the win logic.

## Interface
Parameters:
- `CELL_W`, default 4: bits per cell value (0 = empty, 1-9 = digit).

Ports:
- `clk`  in  1  100 MHz system clock (same domain as engine)
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request to validate current `grid_in`
- `grid_in`  in  81*CELL_W  row-major packed grid; cell (r,c) at bits `[(r*9+c)*CELL_W +: CELL_W]`, r = y, c = x
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse when results update
- `conflict_mask`  out  81  bit r*9+c = 1 if cell conflicts
- `conflict_count`  out  7  number of set bits in `conflict_mask` (0-81)
- `complete`  out  1  all 81 cells nonzero
- `solved`  out  1  `complete` and `conflict_count == 0`

## Operation
- States: IDLE, LOAD, COUNT, MARK, FINISH.
- **IDLE:** `start` = 1 moves to LOAD. `start` is ignored in every other state; there is no queueing.
- **LOAD (1 cycle):**
  - Registers `grid_in` into an internal snapshot. Later changes to `grid_in` do not affect the scan.
  - Clears the working mask, working count and complete accumulator.
  - Sets unit index u = 0 and cell index k = 0.
- **Unit order:** u 0-8 = rows 0-8, u 9-17 = columns 0-8, u 18-26 = boxes 0-8. Box b covers rows 3*(b/3)..+2 and cols 3*(b%3)..+2. Within a box, k walks row-major.
- **COUNT (9 cycles, k = 0..8):**
  - For a cell value v in 1-9: if seen[v] is already set, set dup[v]; otherwise set seen[v].
  - Values 0 and 10-15 are ignored.
- **MARK (9 cycles, k = 0..8):**
  - Set the working mask bit if v is 1-9 and dup[v] is set, or if v is 10-15 (an illegal value always counts as a conflict).
  - Clear seen/dup at the end of MARK. Then advance u; after the last unit go to FINISH, otherwise return to COUNT.
- **complete accumulator:** AND of (v != 0) over row units only.
- **FINISH (1 cycle):**
  - Copies working results to `conflict_mask`, `complete` and `solved`.
  - `conflict_count` = popcount of the final mask. It may be computed incrementally, but the flagged total must not double-count a cell hit by several units.
  - Pulses `done`, then returns to IDLE.
- Outputs hold the last completed scan until the next FINISH. Partial results are never visible.

## Timing
- Let edge 0 be the edge that samples `start` in IDLE.
- `busy` = 1 from edge 1 (LOAD) through the edge entering FINISH. `busy` = 0 in IDLE and is low during the FINISH cycle.
- With boxes enabled:
  - 27 units x 18 cycles = 486 scan cycles.
  - `done` = 1 and outputs update after edge 488.
  - The next `start` is accepted at edge 489 at the earliest.
- Reset values: `busy` 0, `done` 0, `conflict_mask` 0, `conflict_count` 0, `complete` 0, `solved` 0, state IDLE.
- Reset mid-scan: abort on that edge and return to the reset values above. The prior results are lost.
- `start` coincident with `reset`: reset wins.
- `start` held high: rescans back-to-back. Each new scan starts on the first IDLE cycle after FINISH.

## Configuration
- `SUDOKU_VALIDATOR_BOX_EN` defined: all 27 units are scanned; latency as above (`done` after edge 488).
- `SUDOKU_VALIDATOR_BOX_EN` undefined:
  - Box units are omitted, so u runs 0-17.
  - `done` follows edge 1 + 18*18 + 1 = 326.
  - Box-only duplicates are not flagged. `solved` then means "complete with no row/column duplicates".

## Test plan
- **Reset then idle:** all outputs 0 and `busy` 0 for 100 cycles with `start` held 0.
- **Valid solved grid, start pulse:** `done` after edge 488 (326 without the macro), mask 0, count 0, `complete` 1, `solved` 1.
- **Solved grid with cells (0,0) and (0,1) swapped:** both cells create column duplicates. The mask flags the four cells involved, `solved` 0 and `complete` 1.
- **Box-only duplicate:** (0,0) = 5 and (1,1) = 5, with every other cell empty. Macro on: bits 0 and 10 set, count 2. Macro off: mask 0.
- **Illegal value:** cell (4,4) = 12, all other cells empty. Bit 40 set, count 1, `complete` 0, `solved` 0.
- **Busy and reset checks:** a `start` at edge 100 mid-scan is ignored, giving exactly one `done`. Reset asserted at edge 200 of a scan gives immediate zeros and no `done`.
